// File: rtl/quad_encoder_gen_if.sv
// quad_encoder_gen_if: command, abort and encoder-output bundle for quad_encoder_gen
//   cmd_valid/cmd_ready : command handshake
//   cmd_dir             : 1 = forward (A leads B), 0 = reverse
//   cmd_steps           : number of quadrature quarter-steps to emit
//   period              : clock cycles between edges (0 acts as 1)
//   abort               : end the running command early
//   enc_a/enc_b         : registered quadrature outputs
//   busy/done           : command in progress / one-cycle completion pulse
//   position            : free-running edge counter
interface quad_encoder_gen_if #(
    parameter int PERIOD_W = 8,
    parameter int STEPS_W  = 8
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_dir;
    logic [STEPS_W-1:0]  cmd_steps;
    logic [PERIOD_W-1:0] period;
    logic                abort;
    logic                enc_a;
    logic                enc_b;
    logic                busy;
    logic                done;
    logic [STEPS_W-1:0]  position;

    modport master (
        output cmd_valid, cmd_dir, cmd_steps, period, abort,
        input  cmd_ready, enc_a, enc_b, busy, done, position
    );

    modport slave (
        input  cmd_valid, cmd_dir, cmd_steps, period, abort,
        output cmd_ready, enc_a, enc_b, busy, done, position
    );
endinterface

// File: rtl/quad_encoder_gen.sv
// quad_encoder_gen: quadrature encoder pattern generator driven by step commands
//   clk     : system clock, all state on rising edge
//   reset_n : asynchronous active-low reset
//   bus     : quad_encoder_gen_if.slave (command handshake, abort, A/B, busy, done, position)
//   Optional macro QUAD_GEN_BOUNCE_EN: each edge shows new/old/new on the changing
//   channel over three cycles; the effective period is then at least 3.
module quad_encoder_gen #(
    parameter int PERIOD_W = 8,
    parameter int STEPS_W  = 8
) (
    input logic               clk,
    input logic               reset_n,
    quad_encoder_gen_if.slave bus
);
    typedef enum logic [1:0] {IDLE, HOLD, FINISH} state_t;

    state_t              state_q, state_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] per_q, per_d;
    logic [STEPS_W-1:0]  rem_q, rem_d;
    logic [STEPS_W-1:0]  pos_q, pos_d;
    logic                dir_q, dir_d;
    logic [1:0]          ph_q, ph_d;
    logic [1:0]          enc_q, enc_d;
    logic                done_q, done_d;
    logic                step;
    logic [PERIOD_W-1:0] p_eff;

`ifdef QUAD_GEN_BOUNCE_EN
    logic [1:0] bst_q, bst_d;
    logic [1:0] msk_q, msk_d;
    assign p_eff = (bus.period < PERIOD_W'(3)) ? PERIOD_W'(3) : bus.period;
`else
    assign p_eff = (bus.period == '0) ? PERIOD_W'(1) : bus.period;
`endif

    // cnt_q counts down to the next edge; after the last edge it is loaded with
    // P instead of P-1 so the HOLD tail lasts P full cycles past the edge cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        per_d   = per_q;
        rem_d   = rem_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        ph_d    = ph_q;
        done_d  = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    state_d = HOLD;
                    dir_d   = bus.cmd_dir;
                    rem_d   = bus.cmd_steps;
                    per_d   = p_eff;
                    cnt_d   = (bus.cmd_steps == '0) ? '0 : p_eff - PERIOD_W'(1);
                end
            end
            HOLD: begin
                if (bus.abort || (cnt_q == '0 && rem_q == '0)) begin
                    state_d = FINISH;
                    done_d  = 1'b1;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - PERIOD_W'(1);
                end else begin
                    step  = 1'b1;
                    rem_d = rem_q - STEPS_W'(1);
                    cnt_d = (rem_q == STEPS_W'(1)) ? per_q : per_q - PERIOD_W'(1);
                    // {A,B}: forward 00->10->11->01, reverse 00->01->11->10
                    ph_d  = dir_q ? {~ph_q[0], ph_q[1]} : {ph_q[0], ~ph_q[1]};
                    pos_d = dir_q ? pos_q + STEPS_W'(1) : pos_q - STEPS_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef QUAD_GEN_BOUNCE_EN
    // Bounce runs independently of the FSM so it completes even after abort.
    always_comb begin
        enc_d = step ? ph_d : (bst_q == 2'd1) ? enc_q ^ msk_q : (bst_q == 2'd2) ? ph_q : enc_q;
        bst_d = step ? 2'd1 : (bst_q == 2'd1) ? 2'd2 : 2'd0;
        msk_d = step ? ph_d ^ ph_q : msk_q;
    end
`else
    assign enc_d = step ? ph_d : enc_q;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            per_q   <= '0;
            rem_q   <= '0;
            pos_q   <= '0;
            dir_q   <= 1'b0;
            ph_q    <= 2'b00;
            enc_q   <= 2'b00;
            done_q  <= 1'b0;
`ifdef QUAD_GEN_BOUNCE_EN
            bst_q   <= 2'd0;
            msk_q   <= 2'b00;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            rem_q   <= rem_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            ph_q    <= ph_d;
            enc_q   <= enc_d;
            done_q  <= done_d;
`ifdef QUAD_GEN_BOUNCE_EN
            bst_q   <= bst_d;
            msk_q   <= msk_d;
`endif
        end
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.enc_a     = enc_q[1];
    assign bus.enc_b     = enc_q[0];
    assign bus.done      = done_q;
    assign bus.position  = pos_q;
endmodule
